// File: rtl/bsg_two_fifo_width_p97.sv
// Two-entry, 97-bit ready/valid FIFO built on a 1r1w register-file storage.
// Define BSG_TWO_FIFO_ERR_CHECK_EN to enable the sticky protocol-error flag on error_o.

module bsg_mem_1r1w_synth_width_p97_els_p2_read_write_same_addr_p0_harden_p0 #(
  parameter int width_p = 97,
  parameter int els_p   = 2
) (
  input  logic               w_clk_i,
  input  logic               w_reset_i,
  input  logic               w_v_i,
  input  logic [0:0]         w_addr_i,
  input  logic [width_p-1:0] w_data_i,
  input  logic               r_v_i,
  input  logic [0:0]         r_addr_i,
  output logic [width_p-1:0] r_data_o
);

  logic [width_p-1:0] mem_r [els_p];

  // Contents are never cleared; the FIFO's valid state decides what is live.
  for (genvar gi = 0; gi < els_p; gi++) begin : g_entry
    always_ff @(posedge w_clk_i) begin
      if (w_v_i && !w_reset_i && (w_addr_i == 1'(gi))) begin
        mem_r[gi] <= w_data_i;
      end
    end
  end

  // Asynchronous read so a word written on one edge is visible right after it.
  assign r_data_o = r_v_i ? mem_r[r_addr_i] : '0;

endmodule

module bsg_two_fifo_width_p97 #(
  parameter int width_p = 97,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
  output logic               error_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e state_r, state_next;
  logic   wptr_r, rptr_r;
  logic   full_r, empty_r;
  logic   enq, deq;

  assign ready_o = ~full_r & ~reset_i;
  assign v_o     = ~empty_r & ~reset_i;
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  // With one entry held, wptr_r and rptr_r always differ, so a simultaneous
  // enq/deq never reads and writes the same slot.
  bsg_mem_1r1w_synth_width_p97_els_p2_read_write_same_addr_p0_harden_p0 #(
    .width_p (width_p),
    .els_p   (els_p)
  ) mem (
    .w_clk_i   (clk_i),
    .w_reset_i (reset_i),
    .w_v_i     (enq),
    .w_addr_i  (wptr_r),
    .w_data_i  (data_i),
    .r_v_i     (v_o),
    .r_addr_i  (rptr_r),
    .r_data_o  (data_o)
  );

  always_comb begin
    state_next = state_r;
    case (state_r)
      EMPTY:   if (enq) state_next = ONE;
      ONE: begin
        if (enq && !deq)      state_next = FULL;
        else if (deq && !enq) state_next = EMPTY;
      end
      FULL:    if (deq) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= EMPTY;
      wptr_r  <= 1'b0;
      rptr_r  <= 1'b0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      state_r <= state_next;
      wptr_r  <= wptr_r ^ enq;
      rptr_r  <= rptr_r ^ deq;
      empty_r <= (state_next == EMPTY);
      full_r  <= (state_next == FULL);
    end
  end

`ifdef BSG_TWO_FIFO_ERR_CHECK_EN
  logic error_r;

  // Offering data while full, or yanking while empty, latches until reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      error_r <= 1'b0;
    end else if ((v_i && !ready_o) || (yumi_i && !v_o)) begin
      error_r <= 1'b1;
    end
  end

  assign error_o = error_r;
`else
  assign error_o = 1'b0;
`endif

endmodule
